parity_frame_rx: RTL and testbench

Serial receiver that sits directly upstream of the even-parity checking stage. It deserialises one frame from a single-wire line: start bit, DATA_W data bits sent LSB first, one even-parity bit, and a stop bit. It presents the data bits and the received parity bit in parallel to the checker, together with its own parity-error and framing-error flags. Output uses a valid/ready handshake.

---
 rtl/parity_frame_rx_pkg.sv | 8 +
 rtl/rx_bit_timer.sv | 23 ++
 rtl/parity_frame_rx.sv | 86 ++++++++
 tb/tb_parity_frame_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx_pkg: shared types, line constant and parity helper for the receiver and checker stages
package parity_frame_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} rx_state_t;
    localparam logic LINE_IDLE = 1'b1;
    function automatic logic even_parity_err(input logic [31:0] data, input logic parity);
        return ^data ^ parity;
    endfunction
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: mod-CLKS_PER_BIT counter with clear, flags mid-bit and end-of-bit counts
//   clk, rst  : clock, synchronous active-high reset
//   clr       : hold/restart the count at zero
//   half_tick : count == CLKS_PER_BIT/2-1
//   full_tick : count == CLKS_PER_BIT-1
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else cnt <= full_tick ? '0 : cnt + CW'(1);
    end
    assign half_tick = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign full_tick = cnt == CW'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial start/data/even-parity/stop receiver feeding the parity checker
//   rx_in     : serial line, idles high, already synchronised
//   data_out  : received data, LSB = first bit on the line
//   par_out   : received parity bit
//   pec       : even-parity violation flag
//   frame_err : stop bit sampled low
//   valid     : frame held on outputs until valid && ready
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              par_out,
    output logic              pec,
    output logic              frame_err,
    output logic              valid,
    input  logic              ready
);
    localparam int IW = $clog2(DATA_W + 1);
    rx_state_t         state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              par_s;
    logic              clr;
    logic              half_tick;
    logic              full_tick;
    // timer sits at zero while idle and restarts at the confirmed start-bit centre,
    // so every later full_tick lands mid-bit
    assign clr = state == IDLE || (state == START && half_tick);
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            par_s     <= 1'b0;
            data_out  <= '0;
            par_out   <= 1'b0;
            pec       <= 1'b0;
            frame_err <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (rx_in != LINE_IDLE) state <= START;
                START:  if (half_tick) begin
                            state <= rx_in == LINE_IDLE ? IDLE : DATA;
                            idx   <= '0;
                        end
                // right shift: after DATA_W bits the first one received sits at bit 0
                DATA:   if (full_tick) begin
                            shreg <= DATA_W'({rx_in, shreg} >> 1);
                            idx   <= idx + IW'(1);
                            if (idx == IW'(DATA_W - 1)) state <= PARITY;
                        end
                PARITY: if (full_tick) begin
                            par_s <= rx_in;
                            state <= STOP;
                        end
                STOP:   if (full_tick) begin
                            data_out  <= shreg;
                            par_out   <= par_s;
                            pec       <= even_parity_err(32'(shreg), par_s);
                            frame_err <= rx_in != LINE_IDLE;
                            valid     <= 1'b1;
                            state     <= HOLD;
                        end
                HOLD:   if (ready) begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: randomized self-checking bench for parity_frame_rx
module tb_parity_frame_rx;
    localparam int W = 4;
    localparam int C = 4;
    localparam int LAT = C / 2 + (W + 2) * C;

    logic clk = 1'b0;
    logic rst, rx_in, ready;
    logic [W-1:0] data_out;
    logic par_out, pec, frame_err, valid;

    typedef struct packed {
        logic [W-1:0] d;
        logic p;
        logic e;
        logic f;
    } rec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int rises = 0;
    logic valid_p = 1'b0;
    rec_t hs_q[$];

    parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .par_out   (par_out),
        .pec       (pec),
        .frame_err (frame_err),
        .valid     (valid),
        .ready     (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1 && valid_p !== 1'b1) begin
            rise_cyc = cyc;
            rises++;
        end
        if (valid === 1'b1 && ready === 1'b1) hs_q.push_back({data_out, par_out, pec, frame_err});
        valid_p = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic rec_t model(input logic [W-1:0] d, input logic p, input logic s);
        rec_t r;
        r.d = d;
        r.p = p;
        r.e = ($countones({d, p}) % 2) == 1;
        r.f = (s == 1'b0);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s, output int t0);
        t0 = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        rx_in = 1'b1;
    endtask

    task automatic get_rec(output rec_t r, output bit ok);
        ok = 1'b0;
        r = '0;
        for (int i = 0; i < 4 * C && !ok; i++) begin
            if (hs_q.size() > 0) begin
                r = hs_q.pop_front();
                ok = 1'b1;
            end else tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_in = 1'b1;
        ready = 1'b1;
        tick(3);
        rst = 1'b0;
        total++;
        if ({data_out, par_out, pec, frame_err, valid} !== '0) begin
            bad++;
            $display("FAIL reset: outputs=%b want all zero", {data_out, par_out, pec, frame_err, valid});
        end
        hs_q.delete();
    endtask

    task automatic test_frame(input string name, input logic [W-1:0] d, input logic p, input logic s);
        int t0, r0;
        rec_t got, exp;
        bit ok;
        r0 = rises;
        exp = model(d, p, s);
        send_frame(d, p, s, t0);
        get_rec(got, ok);
        total++;
        if (!ok || got !== exp) begin
            bad++;
            $display("FAIL %s frame: got=%b ok=%0d want=%b", name, got, ok, exp);
        end
        total++;
        if (rises != r0 + 1 || rise_cyc - t0 != LAT) begin
            bad++;
            $display("FAIL %s latency: rises=%0d lat=%0d want rises=%0d lat=%0d", name, rises - r0, rise_cyc - t0, 1, LAT);
        end
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL %s valid_drop: valid=%b want 0", name, valid);
        end
    endtask

    task automatic test_false_start;
        int r0;
        r0 = rises;
        rx_in = 1'b0;
        tick(1);
        rx_in = 1'b1;
        tick(3 * C);
        total++;
        if (rises != r0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL false_start: rises=%0d valid=%b want 0 0", rises - r0, valid);
        end
        test_frame("after_false_start", 4'b1111, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        int t0;
        logic [W-1:0] d;
        logic p;
        rec_t got, exp;
        bit ok;
        d = W'($urandom);
        p = 1'($urandom);
        exp = model(d, p, 1'b1);
        ready = 1'b0;
        send_frame(d, p, 1'b1, t0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (valid !== 1'b1 || {data_out, par_out, pec, frame_err} !== exp) begin
                bad++;
                $display("FAIL backpressure hold %0d: valid=%b out=%b want 1 %b", i, valid, {data_out, par_out, pec, frame_err}, exp);
            end
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure release: valid=%b want 0", valid);
        end
        get_rec(got, ok);
        total++;
        if (!ok || got !== exp) begin
            bad++;
            $display("FAIL backpressure handshake: got=%b ok=%0d want=%b", got, ok, exp);
        end
        test_frame("after_backpressure", 4'b1001, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            test_frame("random", W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
            tick($urandom_range(0, 5));
        end
    endtask

    task automatic test_reset_mid;
        int r0;
        test_frame("pre_reset", 4'b0101, 1'b1, 1'b0);
        rx_in = 1'b0;
        tick(C);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_in = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++;
        if ({data_out, par_out, pec, frame_err, valid} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: got=%b want all zero", {data_out, par_out, pec, frame_err, valid});
        end
        r0 = rises;
        tick(LAT + 2 * C);
        total++;
        if (rises != r0) begin
            bad++;
            $display("FAIL reset_mid no_valid: rises=%0d want 0", rises - r0);
        end
        hs_q.delete();
        test_frame("after_reset_mid", 4'b1010, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame("clean", 4'b0110, 1'b0, 1'b1);
        test_frame("parity_err", 4'b0001, 1'b0, 1'b1);
        test_frame("frame_err", 4'b0011, 1'b0, 1'b0);
        test_false_start();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
